// File: rtl/diff_io_pkg.sv
// Shared types and constants for the differential I/O loopback driver.
package diff_io_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
    localparam logic [7:0] ERR_MAX   = 8'hFF;

    // One Fibonacci step: shift toward the MSB, tap parity enters at bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/diff_io_lfsr.sv
// 8-bit pattern generator: reload to the seed or advance one step per request.
module diff_io_lfsr
    import diff_io_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else if (load) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/diff_io_link_driver.sv
// Loopback burst driver for a bidirectional differential pad: sends LFSR bits, checks readback.
// Optional DIFF_IO_SYNC_EN inserts a 2-flop synchronizer on io_o ahead of the compare.
module diff_io_link_driver
    import diff_io_pkg::*;
#(
    parameter int unsigned NUM_BITS       = 32,
    parameter int unsigned BIT_CYCLES     = 4,
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       io_i,
    output logic       io_t,
    input  logic       io_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic       led
);

    localparam int unsigned CNT_MAX = (BIT_CYCLES > RELEASE_CYCLES) ? BIT_CYCLES : RELEASE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = 8;

    if (NUM_BITS < 1 || NUM_BITS > 255) begin : g_bad_num_bits
        $error("NUM_BITS must be in 1..255");
    end
    if (RELEASE_CYCLES < 1) begin : g_bad_release_cycles
        $error("RELEASE_CYCLES must be >= 1");
    end

    logic io_o_cmp;

`ifdef DIFF_IO_SYNC_EN
    if (BIT_CYCLES < 3) begin : g_bad_bit_cycles
        $error("BIT_CYCLES must be >= 3 when DIFF_IO_SYNC_EN is defined");
    end

    logic [1:0] sync;

    // Pad readback is asynchronous to clk when the loop crosses the board.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], io_o};
        end
    end

    assign io_o_cmp = sync[1];
`else
    if (BIT_CYCLES < 1) begin : g_bad_bit_cycles
        $error("BIT_CYCLES must be >= 1");
    end

    assign io_o_cmp = io_o;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cyc_cnt, cyc_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt;
    logic [7:0]       err_nxt;
    logic             pass_nxt;
    logic             io_i_nxt, io_t_nxt, busy_nxt, done_nxt;
    logic             lfsr_load, lfsr_adv, mismatch;
    logic [7:0]       lfsr, lfsr_adv_val;

    diff_io_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .value   (lfsr)
    );

    assign lfsr_adv_val = lfsr_step(lfsr);

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt;
        bit_nxt   = bit_cnt;
        err_nxt   = err_count;
        pass_nxt  = pass;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        io_i_nxt  = 1'b0;
        // Anything other than a clean equal (including X/Z) is a mismatch.
        mismatch  = 1'b1;
        if (io_o_cmp == lfsr[0]) begin
            mismatch = 1'b0;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    cyc_nxt   = '0;
                    bit_nxt   = '0;
                    err_nxt   = 8'd0;
                    pass_nxt  = 1'b0;
                    lfsr_load = 1'b1;
                end
            end
            DRIVE: begin
                if (cyc_cnt == CNT_W'(BIT_CYCLES - 1)) begin
                    cyc_nxt  = '0;
                    lfsr_adv = 1'b1;
                    if (mismatch && (err_count != ERR_MAX)) begin
                        err_nxt = err_count + 8'd1;
                    end
                    if (bit_cnt == BIT_W'(NUM_BITS - 1)) begin
                        state_nxt = RELEASE;
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    cyc_nxt = cyc_cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cyc_cnt == CNT_W'(RELEASE_CYCLES - 1)) begin
                    state_nxt = DONE;
                    cyc_nxt   = '0;
                    pass_nxt  = (err_count == 8'd0);
                end else begin
                    cyc_nxt = cyc_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Pad outputs are registered from the next state so they align with it.
        if (state_nxt == DRIVE) begin
            if (lfsr_load) begin
                io_i_nxt = LFSR_SEED[0];
            end else if (lfsr_adv) begin
                io_i_nxt = lfsr_adv_val[0];
            end else begin
                io_i_nxt = lfsr[0];
            end
        end
        io_t_nxt = (state_nxt != DRIVE);
        busy_nxt = (state_nxt == DRIVE) || (state_nxt == RELEASE);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            err_count <= 8'd0;
            pass      <= 1'b0;
            io_i      <= 1'b0;
            io_t      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cyc_cnt   <= cyc_nxt;
            bit_cnt   <= bit_nxt;
            err_count <= err_nxt;
            pass      <= pass_nxt;
            io_i      <= io_i_nxt;
            io_t      <= io_t_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    assign led = pass;

endmodule
